// File: rtl/exec_pkg.sv
// Shared constants for the multicycle execute unit: MIPS R-type funct codes
// and the two-state sequencing encoding.
package exec_pkg;

  localparam logic [5:0] F_NOP   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ITER  = 1'b1;

endpackage

// File: rtl/multicycle_exec_unit_if.sv
// Issue/result bundle between the ID/EX register and the execute unit.
// master = upstream pipeline, slave = execute unit.
interface multicycle_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             div_by_zero;
  logic             illegal;

  modport master (
    output in_valid, funct, dataA, dataB,
    input  in_ready, out_valid, result, zero, busy, div_by_zero, illegal
  );

  modport slave (
    input  in_valid, funct, dataA, dataB,
    output in_ready, out_valid, result, zero, busy, div_by_zero, illegal
  );
endinterface

// File: rtl/serial_divider.sv
// Restoring unsigned divider, DIV_BITS quotient bits per edge over N_ITER edges.
// quotient/remainder/done are the values produced by the current edge's step.
module serial_divider #(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int N_ITER = WIDTH / DIV_BITS;
  localparam int CW     = $clog2(N_ITER);

  logic [WIDTH-1:0] rem_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] dsr_p1;
  logic [CW-1:0]    cnt_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH:0]   trial;

  // quo_p1 starts as the dividend; its bits shift out into the remainder
  // while quotient bits shift in from the bottom.
  always_comb begin
    rem_nx = rem_p1;
    quo_nx = quo_p1;
    trial  = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial  = {rem_nx, quo_nx[WIDTH-1]};
      quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dsr_p1}) begin
        trial     = trial - {1'b0, dsr_p1};
        quo_nx[0] = 1'b1;
      end
      rem_nx = trial[WIDTH-1:0];
    end
  end

  assign quotient  = quo_nx;
  assign remainder = rem_nx;
  assign done      = vld_p1 && (cnt_p1 == CW'(N_ITER - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (start) begin
      vld_p1 <= 1'b1;
      cnt_p1 <= '0;
    end else if (vld_p1) begin
      cnt_p1 <= cnt_p1 + 1'b1;
      if (done) vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem_p1 <= '0;
      quo_p1 <= dividend;
      dsr_p1 <= divisor;
    end else if (vld_p1) begin
      rem_p1 <= rem_nx;
      quo_p1 <= quo_nx;
    end
  end

endmodule

// File: rtl/multicycle_exec_unit.sv
// Single-issue execute unit: one-cycle ALU ops, iterative DIVU into HI/LO.
// Define EXEC_MULTU_EN to enable iterative MULTU (funct 25); otherwise it is illegal.
module multicycle_exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [0:0]       state_p1;
  logic [WIDTH-1:0] hi_p1;
  logic [WIDTH-1:0] lo_p1;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             vld_p1;
  logic             dbz_p1;
  logic             ill_p1;
  logic             dbz_pend_p1;

  logic             accept_p0;
  logic             is_iter_p0;
  logic             is_single_p0;
  logic [WIDTH-1:0] alu_p0;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_done;

  function automatic logic slt_signed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    return sa < sb;
  endfunction

  assign accept_p0 = bus.in_valid && (state_p1 == S_IDLE);

`ifdef EXEC_MULTU_EN
  assign is_iter_p0 = (bus.funct == F_DIVU) || (bus.funct == F_MULTU);
`else
  assign is_iter_p0 = (bus.funct == F_DIVU);
`endif

  always_comb begin
    alu_p0       = '0;
    is_single_p0 = 1'b1;
    case (bus.funct)
      F_ADD:   alu_p0 = bus.dataA + bus.dataB;
      F_SUB:   alu_p0 = bus.dataA - bus.dataB;
      F_AND:   alu_p0 = bus.dataA & bus.dataB;
      F_OR:    alu_p0 = bus.dataA | bus.dataB;
      F_SLT:   alu_p0 = {{(WIDTH-1){1'b0}}, slt_signed(bus.dataA, bus.dataB)};
      F_SRL:   alu_p0 = bus.dataB >> bus.dataA[SHW-1:0];
      F_MFHI:  alu_p0 = hi_p1;
      F_MFLO:  alu_p0 = lo_p1;
      default: is_single_p0 = 1'b0;
    endcase
  end

  // The divider's counter also times MULTU, so it is started for both ops.
  serial_divider #(
    .WIDTH    (WIDTH),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept_p0 && is_iter_p0),
    .dividend  (bus.dataA),
    .divisor   (bus.dataB),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

`ifdef EXEC_MULTU_EN
  logic [WIDTH-1:0] mul_hi_p1;
  logic [WIDTH-1:0] mul_lo_p1;
  logic [WIDTH-1:0] mcand_p1;
  logic             op_mul_p1;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;
  logic [WIDTH:0]   mul_sum;

  // LSB-first shift-add: {hi,lo} starts as {0, multiplier}.
  always_comb begin
    mul_hi_nx = mul_hi_p1;
    mul_lo_nx = mul_lo_p1;
    mul_sum   = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      mul_sum   = {1'b0, mul_hi_nx} + (mul_lo_nx[0] ? {1'b0, mcand_p1} : '0);
      mul_lo_nx = {mul_sum[0], mul_lo_nx[WIDTH-1:1]};
      mul_hi_nx = mul_sum[WIDTH:1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0 && (bus.funct == F_MULTU)) begin
      mul_hi_p1 <= '0;
      mul_lo_p1 <= bus.dataB;
      mcand_p1  <= bus.dataA;
    end else if (state_p1 == S_ITER) begin
      mul_hi_p1 <= mul_hi_nx;
      mul_lo_p1 <= mul_lo_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1    <= S_IDLE;
      hi_p1       <= '0;
      lo_p1       <= '0;
      result_p1   <= '0;
      zero_p1     <= 1'b1;
      vld_p1      <= 1'b0;
      dbz_p1      <= 1'b0;
      ill_p1      <= 1'b0;
      dbz_pend_p1 <= 1'b0;
`ifdef EXEC_MULTU_EN
      op_mul_p1   <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      dbz_p1 <= 1'b0;
      ill_p1 <= 1'b0;
      if (state_p1 == S_ITER) begin
        if (div_done) begin
          state_p1  <= S_IDLE;
          vld_p1    <= 1'b1;
          result_p1 <= '0;
          zero_p1   <= 1'b1;
          dbz_p1    <= dbz_pend_p1;
`ifdef EXEC_MULTU_EN
          if (op_mul_p1) begin
            hi_p1 <= mul_hi_nx;
            lo_p1 <= mul_lo_nx;
          end else begin
            hi_p1 <= div_rem;
            lo_p1 <= div_quo;
          end
`else
          hi_p1 <= div_rem;
          lo_p1 <= div_quo;
`endif
        end
      end else if (accept_p0) begin
        if (is_iter_p0) begin
          state_p1    <= S_ITER;
          dbz_pend_p1 <= (bus.funct == F_DIVU) && (bus.dataB == '0);
`ifdef EXEC_MULTU_EN
          op_mul_p1   <= (bus.funct == F_MULTU);
`endif
        end else if (is_single_p0) begin
          result_p1 <= alu_p0;
          zero_p1   <= (alu_p0 == '0);
          vld_p1    <= 1'b1;
        end else if (bus.funct != F_NOP) begin
          result_p1 <= '0;
          zero_p1   <= 1'b1;
          vld_p1    <= 1'b1;
          ill_p1    <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready    = (state_p1 == S_IDLE);
  assign bus.busy        = (state_p1 == S_ITER);
  assign bus.out_valid   = vld_p1;
  assign bus.result      = result_p1;
  assign bus.zero        = zero_p1;
  assign bus.div_by_zero = dbz_p1;
  assign bus.illegal     = ill_p1;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Directed bench for multicycle_exec_unit (WIDTH=32, DIV_BITS=1).
module tb_multicycle_exec_unit;
  import exec_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_exec_unit_if #(.WIDTH(32)) bus ();

  multicycle_exec_unit #(.WIDTH(32), .DIV_BITS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.funct    = f;
    bus.dataA    = a;
    bus.dataB    = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until out_valid (bounded), counting busy samples on the way.
  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      step();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 00000000", bus.result); end
    n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", bus.zero); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if ({bus.illegal, bus.div_by_zero} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {bus.illegal, bus.div_by_zero}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, F_ADD, 32'hFFFF_FFFF, 32'h1);
    step();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL add_wrap got %h want 00000000", bus.result); end
    n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL add_zero got %b want 1", bus.zero); end
    drive(1'b1, F_SUB, 32'h3, 32'h5);
    step();
    n_cmp++; if (bus.result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_wrap got %h want fffffffe", bus.result); end
    n_cmp++; if ({bus.out_valid, bus.zero} !== 2'b10) begin n_bad++; $display("FAIL sub_valid_zero got %b want 10", {bus.out_valid, bus.zero}); end
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL idle_hold got %h want fffffffe", bus.result); end
  endtask

  task automatic test_logic_ops();
    drive(1'b1, F_SLT, 32'hFFFF_FFFF, 32'h1);
    step();
    n_cmp++; if (bus.result !== 32'h1) begin n_bad++; $display("FAIL slt_neg got %h want 00000001", bus.result); end
    drive(1'b1, F_SLT, 32'h1, 32'hFFFF_FFFF);
    step();
    n_cmp++; if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin n_bad++; $display("FAIL slt_pos got %h/%b want 00000000/1", bus.result, bus.zero); end
    drive(1'b1, F_SRL, 32'h4, 32'h8000_0000);
    step();
    n_cmp++; if (bus.result !== 32'h0800_0000) begin n_bad++; $display("FAIL srl got %h want 08000000", bus.result); end
    drive(1'b1, F_AND, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    n_cmp++; if (bus.result !== 32'h0000_F000) begin n_bad++; $display("FAIL and got %h want 0000f000", bus.result); end
    drive(1'b1, F_OR, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    n_cmp++; if (bus.result !== 32'h0000_FFF0) begin n_bad++; $display("FAIL or got %h want 0000fff0", bus.result); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_divu();
    int busy_n;
    bit seen;
    drive(1'b1, F_DIVU, 32'd100, 32'd7);
    step();
    // MFHI held while busy; it must only be taken in the completion cycle.
    drive(1'b1, F_MFHI, 32'hDEAD_BEEF, 32'h0);
    n_cmp++; if ({bus.busy, bus.in_ready} !== 2'b10) begin n_bad++; $display("FAIL divu_busy_ready got %b want 10", {bus.busy, bus.in_ready}); end
    wait_done(busy_n, seen);
    n_cmp++; if (!seen || busy_n != 32) begin n_bad++; $display("FAIL divu_latency got seen=%0d busy=%0d want seen=1 busy=32", seen, busy_n); end
    n_cmp++; if ({bus.result, bus.div_by_zero, bus.in_ready} !== {32'h0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL divu_done got %h/%b/%b want 00000000/0/1", bus.result, bus.div_by_zero, bus.in_ready); end
    step();
    n_cmp++; if ({bus.out_valid, bus.result} !== {1'b1, 32'd2}) begin n_bad++; $display("FAIL divu_mfhi got %b/%h want 1/00000002", bus.out_valid, bus.result); end
    drive(1'b1, F_MFLO, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'd14) begin n_bad++; $display("FAIL divu_mflo got %h want 0000000e", bus.result); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_div_zero();
    int busy_n;
    bit seen;
    drive(1'b1, F_DIVU, 32'h1234, 32'h0);
    step();
    drive(1'b1, F_ADD, 32'h1, 32'h1);
    wait_done(busy_n, seen);
    n_cmp++; if (!seen || busy_n != 32) begin n_bad++; $display("FAIL dbz_latency got seen=%0d busy=%0d want seen=1 busy=32", seen, busy_n); end
    n_cmp++; if (bus.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got %b want 1", bus.div_by_zero); end
    drive(1'b1, F_MFLO, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_lo got %h want ffffffff", bus.result); end
    drive(1'b1, F_MFHI, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'h1234) begin n_bad++; $display("FAIL dbz_hi got %h want 00001234", bus.result); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid_div();
    int spurious;
    drive(1'b1, F_DIVU, 32'd100, 32'd7);
    step();
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    repeat (9) step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy got %b want 1", bus.busy); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001) begin n_bad++; $display("FAIL abort_state got %b want 001", {bus.busy, bus.out_valid, bus.in_ready}); end
    #2 reset = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) spurious++;
    end
    n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL abort_no_valid got %0d pulses want 0", spurious); end
    drive(1'b1, F_MFHI, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL abort_hi got %h want 00000000", bus.result); end
    drive(1'b1, F_MFLO, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL abort_lo got %h want 00000000", bus.result); end
    drive(1'b1, F_ADD, 32'd2, 32'd3);
    step();
    n_cmp++; if ({bus.out_valid, bus.result} !== {1'b1, 32'd5}) begin n_bad++; $display("FAIL abort_add got %b/%h want 1/00000005", bus.out_valid, bus.result); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_illegal_nop();
    drive(1'b1, F_NOP, 32'h1, 32'h1);
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL nop_valid got %b want 0", bus.out_valid); end
    n_cmp++; if ({bus.result, bus.zero} !== {32'd5, 1'b0}) begin n_bad++; $display("FAIL nop_hold got %h/%b want 00000005/0", bus.result, bus.zero); end
    drive(1'b1, 6'h3F, 32'h1, 32'h1);
    step();
    n_cmp++; if ({bus.out_valid, bus.illegal, bus.result, bus.zero} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin n_bad++; $display("FAIL illegal_3f got %b/%b/%h/%b want 1/1/00000000/1", bus.out_valid, bus.illegal, bus.result, bus.zero); end
    drive(1'b1, F_ADD, 32'h1, 32'h1);
    step();
    n_cmp++; if ({bus.illegal, bus.result} !== {1'b0, 32'd2}) begin n_bad++; $display("FAIL illegal_clear got %b/%h want 0/00000002", bus.illegal, bus.result); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask

`ifdef EXEC_MULTU_EN
  task automatic test_multu();
    int busy_n;
    bit seen;
    drive(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'h2);
    step();
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    wait_done(busy_n, seen);
    n_cmp++; if (!seen || busy_n != 32) begin n_bad++; $display("FAIL multu_latency got seen=%0d busy=%0d want seen=1 busy=32", seen, busy_n); end
    n_cmp++; if ({bus.div_by_zero, bus.result} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL multu_done got %b/%h want 0/00000000", bus.div_by_zero, bus.result); end
    drive(1'b1, F_MFHI, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'h1) begin n_bad++; $display("FAIL multu_hi got %h want 00000001", bus.result); end
    drive(1'b1, F_MFLO, 32'h0, 32'h0);
    step();
    n_cmp++; if (bus.result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo got %h want fffffffe", bus.result); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask
`else
  task automatic test_multu();
    drive(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'h2);
    step();
    n_cmp++; if ({bus.out_valid, bus.illegal, bus.busy} !== 3'b110) begin n_bad++; $display("FAIL multu_illegal got %b want 110", {bus.out_valid, bus.illegal, bus.busy}); end
    drive(1'b0, F_NOP, 32'h0, 32'h0);
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_logic_ops();
    test_divu();
    test_div_zero();
    test_reset_mid_div();
    test_illegal_nop();
    test_multu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_exec_unit.md
Name: multicycle_exec_unit

Overview:
- Parametrised successor to the current execute-stage ALU wrapper.
- Single-issue execute unit: one-cycle logic/arith/shift ops plus an iterative unsigned divider writing internal HI/LO; MFHI/MFLO read them back.
- Explicit valid/ready handshake replaces free-running divide sequencing, so the pipeline stalls cleanly while a divide is in flight.
- Sits between ID/EX pipeline register and EX/MEM; `zero` feeds branch logic.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8.
- DIV_BITS, 1, quotient bits per iteration (1 or 2); WIDTH divisible by DIV_BITS.
- Derived localparams: N_ITER = WIDTH/DIV_BITS; SHW = log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready
- funct  in  6  MIPS R-type funct code
- dataA  in  WIDTH  rs operand
- dataB  in  WIDTH  rt operand
- out_valid  out  1  one-cycle result pulse
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- busy  out  1  iterative op in progress
- div_by_zero  out  1  qualified by out_valid; DIVU had dataB == 0
- illegal  out  1  qualified by out_valid; unsupported funct

Behaviour:
- Reset (async, low): state IDLE, HI = LO = 0, result = 0, zero = 1, out_valid = busy = div_by_zero = illegal = 0, iteration counter = 0. Reset mid-divide aborts it; no out_valid afterwards.
- States: IDLE, ITER.
- in_ready = (state == IDLE). busy = (state == ITER).
- Single-cycle ops, accepted at edge T0: result/zero/out_valid valid in the cycle after T0. Back-to-back acceptance every cycle is allowed.
  - ADD (32): A+B, wraps.
  - SUB (34): A-B, wraps. No overflow trap for ADD/SUB.
  - AND (36), OR (37): bitwise.
  - SLT (42): signed compare, result 1 or 0.
  - SRL (2): dataB >> dataA[SHW-1:0], logical.
  - MFHI (16) / MFLO (18): current HI / LO.
- NOP (funct 0): accepted, no out_valid. Result and zero hold their previous values.
- Any other funct: accepted; out_valid pulses with result = 0, illegal = 1.
- DIVU (27), accepted at T0:
  - IDLE -> ITER. Operands latched at T0; later input changes are ignored.
  - Restoring division, DIV_BITS per edge, for N_ITER edges T1..TN; at TN state returns to IDLE.
  - Edge TN also writes HI = remainder, LO = quotient.
  - out_valid pulses the cycle after TN with result = 0, div_by_zero set if applicable.
  - in_ready is high in that same cycle.
  - Latency WIDTH=32, DIV_BITS=1: 32 busy cycles; out_valid in the 33rd cycle after acceptance.
- Divide by zero: quotient = all ones, remainder = dividend, full N_ITER latency kept.
- MFHI/MFLO accepted in the out_valid cycle of a DIVU sees the new HI/LO.
- in_valid while busy: not accepted; upstream holds the operation.
- out_valid is deasserted in every cycle without a completing operation. result holds its last value.

Optional Feature:
- Macro EXEC_MULTU_EN.
- Defined: funct 25 (MULTU) enabled. Iterative shift-add over N_ITER edges, sharing the ITER state and counter. {HI,LO} = 2*WIDTH-bit unsigned product. Completion pulse identical to DIVU; div_by_zero = 0.
- Undefined: funct 25 is illegal.

Decomposition:
- Package exec_pkg: funct code constants (AND, OR, ADD, SUB, SLT, SRL, DIVU, MULTU, MFHI, MFLO, NOP) and state encoding.
- One sub-module, serial_divider:
  - Inputs: start, dividend, divisor. Outputs: quotient, remainder, done.
  - Parametrised WIDTH/DIV_BITS, same clk/reset.
  - The top owns the FSM, HI/LO and output registers.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF B=1 -> next cycle out_valid=1, result=0, zero=1. SUB A=3 B=5 issued back-to-back -> result=0xFFFFFFFE.
- SLT A=0xFFFFFFFF B=1 -> result=1. SRL A=4 B=0x80000000 -> result=0x08000000.
- DIVU A=100 B=7 -> busy 32 cycles, in_ready=0; then out_valid. MFHI -> 2, MFLO -> 14.
- DIVU A=0x1234 B=0 -> div_by_zero=1. MFLO -> 0xFFFFFFFF, MFHI -> 0x1234.
- Assert reset at cycle 10 of a divide -> busy=0, HI=LO=0, no out_valid; a following ADD works normally.
- funct=0x3F -> illegal=1, result=0. funct=0 -> no out_valid. With EXEC_MULTU_EN, MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
